// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 slave front end for a parametrised data memory: decodes an address/RW header,
// then bursts DATA_W-bit words with auto-incrementing address in either direction.
module spi_mem_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              sclk_pos,
   input  logic              sclk_neg,
   input  logic              mosi,
   output logic              miso_out,
   output logic              miso_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   output logic              busy,
   output logic              frame_err
);

   // rx_sr only ever needs the bits preceding the final (directly used) mosi bit
   localparam int RX_W  = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
   localparam int CNT_W = $clog2(RX_W + 1);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, HDR, LOAD, DATA} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [RX_W-1:0]   rx_sr;
   logic [DATA_W-1:0] tx_sr;
   logic              rw;
   logic              cs_q;
   logic              cnt_clr, cnt_inc, rx_shift, hdr_done;
   logic              wr_done, rd_done, tx_load, tx_shift, abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      rx_shift  = 1'b0;
      hdr_done  = 1'b0;
      wr_done   = 1'b0;
      rd_done   = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
      abort     = 1'b0;
      busy      = (state != IDLE);
      miso_en   = rw && (state == LOAD || state == DATA);
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            // cs_q requires a high level first, so a frame cut by reset cannot resume
            if (!cs && cs_q) state_nxt = HDR;
         end
         HDR: begin
            if (cs) begin
               state_nxt = IDLE;
               cnt_clr   = 1'b1;
               abort     = (cnt != '0);
            end else if (sclk_pos) begin
               rx_shift = 1'b1;
               if (cnt == HDR_LAST) begin
                  hdr_done  = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = mosi ? LOAD : DATA;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         LOAD: begin
            if (cs) begin
               state_nxt = IDLE;
            end else begin
               tx_load   = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (cs) begin
               state_nxt = IDLE;
               cnt_clr   = 1'b1;
               abort     = (cnt != '0);
            end else if (sclk_pos) begin
               rx_shift = !rw;
               if (cnt == WORD_LAST) begin
                  cnt_clr = 1'b1;
                  if (rw) begin
                     rd_done   = 1'b1;
                     state_nxt = LOAD;
                  end else begin
                     wr_done = 1'b1;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (sclk_neg && rw && cnt != '0) begin
               tx_shift = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         rw        <= 1'b0;
         cs_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cs_q      <= cs;
         mem_we    <= wr_done;
         frame_err <= abort;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
         if (rx_shift) rx_sr <= {rx_sr[RX_W-2:0], mosi};
         // the address advances after the write strobe so it stays stable during mem_we
         if (hdr_done) begin
            mem_addr <= rx_sr[ADDR_W-1:0];
            rw       <= mosi;
         end else if (mem_we || rd_done) begin
            mem_addr <= mem_addr + 1'b1;
         end
         if (wr_done) mem_wdata <= {rx_sr[DATA_W-2:0], mosi};
         if (tx_load)       tx_sr <= mem_rdata;
         else if (tx_shift) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
   end

   assign miso_out = tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl: one default-sized instance (A) and one 10/16-bit instance (B)
// sharing the serial strobes, each with its own chip select and behavioural memory.
module tb_spi_mem_ctrl;

   logic clk, reset, cs_a, cs_b, sclk_pos, sclk_neg, mosi, mem_init;

   logic        miso_out_a, miso_en_a, mem_we_a, busy_a, frame_err_a;
   logic [6:0]  mem_addr_a;
   logic [7:0]  mem_wdata_a, mem_rdata_a;
   logic [7:0]  mem_a [128];

   logic        miso_out_b, miso_en_b, mem_we_b, busy_b, frame_err_b;
   logic [9:0]  mem_addr_b;
   logic [15:0] mem_wdata_b, mem_rdata_b;
   logic [15:0] mem_b [1024];

   int n_checks = 0;
   int n_err    = 0;

   logic [14:0] exp_wr_a[$];
   logic        exp_miso_a[$];
   logic        exp_err_a[$];
   logic        exp_miso_b[$];
   logic        miso_en_seen_a;

   spi_mem_ctrl dut_a (
      .clk(clk), .reset(reset), .cs(cs_a), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
      .mosi(mosi), .miso_out(miso_out_a), .miso_en(miso_en_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .mem_we(mem_we_a),
      .busy(busy_a), .frame_err(frame_err_a)
   );

   spi_mem_ctrl #(.ADDR_W(10), .DATA_W(16)) dut_b (
      .clk(clk), .reset(reset), .cs(cs_b), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
      .mosi(mosi), .miso_out(miso_out_b), .miso_en(miso_en_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_we(mem_we_b),
      .busy(busy_b), .frame_err(frame_err_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   assign mem_rdata_a = mem_a[mem_addr_a];
   assign mem_rdata_b = mem_b[mem_addr_b];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) mem_a[i] <= 8'(i * 3);
         for (int i = 0; i < 1024; i++) mem_b[i] <= 16'(i);
         mem_a[7'h2A]  <= 8'h3C;
         mem_b[10'h3FF] <= 16'hBEEF;
         mem_b[10'h000] <= 16'h1234;
      end else begin
         if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
         if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_err++;
      $display("FAIL %s: actual=%0h required=no event", name, act);
   endtask

   // Monitor: sample half a cycle after the edge, i.e. the values the DUT presents to the next edge
   always begin
      logic [14:0] ew;
      logic        eb;
      @(negedge clk);
      #1;
      if (miso_en_a) miso_en_seen_a = 1'b1;
      if (mem_we_a) begin
         if (exp_wr_a.size() == 0) unexpected("mem_we_a", 32'({mem_addr_a, mem_wdata_a}));
         else begin
            ew = exp_wr_a.pop_front();
            check("write_a addr/data", 32'({mem_addr_a, mem_wdata_a}), 32'(ew));
         end
      end
      if (sclk_pos && miso_en_a) begin
         if (exp_miso_a.size() == 0) unexpected("miso_a", 32'(miso_out_a));
         else begin
            eb = exp_miso_a.pop_front();
            check("miso_a bit", 32'(miso_out_a), 32'(eb));
         end
      end
      if (frame_err_a) begin
         if (exp_err_a.size() == 0) unexpected("frame_err_a", 32'(frame_err_a));
         else begin
            eb = exp_err_a.pop_front();
            check("frame_err_a", 32'(frame_err_a), 32'(eb));
         end
      end
      if (mem_we_b) unexpected("mem_we_b", 32'({mem_addr_b, mem_wdata_b}));
      if (frame_err_b) unexpected("frame_err_b", 32'(frame_err_b));
      if (sclk_pos && miso_en_b) begin
         if (exp_miso_b.size() == 0) unexpected("miso_b", 32'(miso_out_b));
         else begin
            eb = exp_miso_b.pop_front();
            check("miso_b bit", 32'(miso_out_b), 32'(eb));
         end
      end
   end

   task automatic spi_bit(input logic b);
      @(negedge clk);
      mosi = b;
      repeat (3) @(negedge clk);
      sclk_pos = 1'b1;
      @(negedge clk);
      sclk_pos = 1'b0;
      repeat (3) @(negedge clk);
      sclk_neg = 1'b1;
      @(negedge clk);
      sclk_neg = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
   endtask

   task automatic cs_set(input int sel, input logic lvl);
      @(negedge clk);
      if (sel == 0) cs_a = lvl;
      else          cs_b = lvl;
      repeat (2) @(negedge clk);
   endtask

   task automatic push_word_a(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) exp_miso_a.push_back(w[i]);
   endtask

   task automatic push_word_b(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) exp_miso_b.push_back(w[i]);
   endtask

   initial begin
      reset = 1'b1; cs_a = 1'b1; cs_b = 1'b1;
      sclk_pos = 1'b0; sclk_neg = 1'b0; mosi = 1'b0; mem_init = 1'b1;
      miso_en_seen_a = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_a ctrl", 32'({miso_out_a, miso_en_a, mem_we_a, busy_a, frame_err_a}), 32'h0);
      check("reset_a addr", 32'(mem_addr_a), 32'h0);
      check("reset_a wdata", 32'(mem_wdata_a), 32'h0);
      check("reset_b ctrl", 32'({miso_out_b, miso_en_b, mem_we_b, busy_b, frame_err_b}), 32'h0);
      check("reset_b addr", 32'(mem_addr_b), 32'h0);
      check("reset_b wdata", 32'(mem_wdata_b), 32'h0);
      @(negedge clk);
      mem_init = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("idle busy_a", 32'(busy_a), 32'h0);
      check("idle busy_b", 32'(busy_b), 32'h0);

      // single write 0x15 <- 0xA5
      miso_en_seen_a = 1'b0;
      exp_wr_a.push_back({7'h15, 8'hA5});
      cs_set(0, 1'b0);
      check("busy_a in frame", 32'(busy_a), 32'h1);
      send_bits(32'((7'h15 << 1) | 0), 8);
      send_bits(32'h0A5, 8);
      cs_set(0, 1'b1);
      check("write miso_en_a quiet", 32'(miso_en_seen_a), 32'h0);
      check("mem_a[15]", 32'(mem_a[7'h15]), 32'hA5);

      // single read 0x2A -> 0x3C
      push_word_a(8'h3C);
      cs_set(0, 1'b0);
      send_bits(32'((7'h2A << 1) | 1), 8);
      send_bits(32'h0, 8);
      #1;
      check("read miso_en_a high", 32'(miso_en_a), 32'h1);
      cs_set(0, 1'b1);
      #1;
      check("read miso_en_a after cs", 32'(miso_en_a), 32'h0);
      check("read busy_a after cs", 32'(busy_a), 32'h0);

      // burst write across the top of the address space
      exp_wr_a.push_back({7'h7E, 8'h11});
      exp_wr_a.push_back({7'h7F, 8'h22});
      exp_wr_a.push_back({7'h00, 8'h33});
      cs_set(0, 1'b0);
      send_bits(32'((7'h7E << 1) | 0), 8);
      send_bits(32'h11, 8);
      send_bits(32'h22, 8);
      send_bits(32'h33, 8);
      cs_set(0, 1'b1);
      check("mem_a[7E]", 32'(mem_a[7'h7E]), 32'h11);
      check("mem_a[7F]", 32'(mem_a[7'h7F]), 32'h22);
      check("mem_a[00]", 32'(mem_a[7'h00]), 32'h33);

      // abort after 5 data bits
      exp_err_a.push_back(1'b1);
      cs_set(0, 1'b0);
      send_bits(32'((7'h05 << 1) | 0), 8);
      send_bits(32'h15, 5);
      @(negedge clk);
      cs_a = 1'b1;
      @(negedge clk);
      #1;
      check("abort busy_a next clk", 32'(busy_a), 32'h0);
      repeat (3) @(negedge clk);
      check("abort mem_a[05]", 32'(mem_a[7'h05]), 32'h0F);

      // B: burst read from 0x3FF wrapping to 0x000
      push_word_b(16'hBEEF);
      push_word_b(16'h1234);
      cs_set(1, 1'b0);
      send_bits(32'((10'h3FF << 1) | 1), 11);
      send_bits(32'h0, 16);
      send_bits(32'h0, 16);
      cs_set(1, 1'b1);
      check("burst busy_b after cs", 32'(busy_b), 32'h0);

      // reset in the middle of a read word
      exp_miso_a.push_back(1'b0);
      exp_miso_a.push_back(1'b0);
      exp_miso_a.push_back(1'b1);
      cs_set(0, 1'b0);
      send_bits(32'((7'h2A << 1) | 1), 8);
      send_bits(32'h0, 3);
      #1;
      check("busy_a before reset", 32'(busy_a), 32'h1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async reset ctrl", 32'({miso_out_a, miso_en_a, mem_we_a, busy_a, frame_err_a}), 32'h0);
      check("async reset addr", 32'(mem_addr_a), 32'h0);
      check("async reset wdata", 32'(mem_wdata_a), 32'h0);
      cs_a = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("busy_a after reset release", 32'(busy_a), 32'h0);

      repeat (4) @(negedge clk);
      check("pending writes a", 32'(exp_wr_a.size()), 32'h0);
      check("pending miso a", 32'(exp_miso_a.size()), 32'h0);
      check("pending frame_err a", 32'(exp_err_a.size()), 32'h0);
      check("pending miso b", 32'(exp_miso_b.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
